// File: rtl/irq_event_collector.sv
// Per-source event latch with a coalescing delay, presenting a registered irq vector
// to the interrupt-capable register bank, which acknowledges it with irq_reset.
module irq_event_collector #(
    parameter int                 num_irq     = 1,
    parameter logic [num_irq-1:0] edge_mask   = {num_irq{1'b1}},
    parameter int                 count_width = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [num_irq-1:0]     event_in,
    input  logic [num_irq-1:0]     irq_enable,
    input  logic [count_width-1:0] coalesce_cycles,
    input  logic                   irq_reset,
    output logic [num_irq-1:0]     irq,
    output logic [num_irq-1:0]     overflow
);

    typedef enum logic [1:0] {IDLE, WAIT, ASSERT} state_t;

    state_t                 state_q, state_d;
    logic [count_width-1:0] cnt_q, cnt_d;
    logic [num_irq-1:0]     event_prev_q;
    logic [num_irq-1:0]     pending_q, pending_d;
    logic [num_irq-1:0]     overflow_q, overflow_d;
    logic [num_irq-1:0]     irq_q, irq_d;
    logic [num_irq-1:0]     hit, live, ack_clr;

    assign hit  = (event_in & ~event_prev_q & edge_mask) | (event_in & ~edge_mask);
    assign live = pending_q & irq_enable;

    // A hit coinciding with its own acknowledge keeps the bit pending without flagging overflow.
    always_comb begin
        pending_d  = (pending_q & ~ack_clr) | hit;
        overflow_d = (overflow_q & ~ack_clr) | (hit & pending_q & ~ack_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            event_prev_q <= '0;
            pending_q    <= '0;
            overflow_q   <= '0;
            irq_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            event_prev_q <= event_in;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            irq_q        <= irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|live) begin
                    if (coalesce_cycles == '0) begin
                        state_d = ASSERT;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = coalesce_cycles - 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = ASSERT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ASSERT: begin
                if (irq_reset || !(|live)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Acknowledge clears only what the bank actually saw in irq.
    always_comb begin
        ack_clr = (state_q == ASSERT && irq_reset) ? irq_q : '0;
        irq_d   = (state_q == ASSERT && state_d == ASSERT) ? live : '0;
    end

    assign irq      = irq_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_irq_event_collector.sv
// Directed vector table plus randomized traffic, both compared against a
// cycle-countdown reference model of the interrupt collector.
module tb_irq_event_collector;

    localparam int         N  = 4;
    localparam logic [3:0] EM = 4'b1110;   // bit 0 level, others edge

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  event_in, irq_enable, irq, overflow;
    logic [15:0] coalesce_cycles;
    logic        irq_reset;

    int checks = 0;
    int errors = 0;

    irq_event_collector #(.num_irq(N), .edge_mask(EM), .count_width(16)) dut (
        .clk(clk), .rst(rst), .event_in(event_in), .irq_enable(irq_enable),
        .coalesce_cycles(coalesce_cycles), .irq_reset(irq_reset),
        .irq(irq), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Model: left < 0 = no interrupt in progress, left > 0 = cycles still to wait,
    // left == 0 = interrupt being presented.
    typedef struct {
        logic [3:0] prev, pend, ovf, irq;
        int         left;
    } model_t;

    model_t m = '{prev: 4'h0, pend: 4'h0, ovf: 4'h0, irq: 4'h0, left: -1};

    function automatic model_t step(model_t s, logic r, logic [3:0] ev, logic [3:0] en,
                                    int cc, logic ack);
        model_t     n;
        logic [3:0] hit, live, clr;
        n = s;
        if (r) begin
            n = '{prev: 4'h0, pend: 4'h0, ovf: 4'h0, irq: 4'h0, left: -1};
            return n;
        end
        hit    = (ev & ~s.prev & EM) | (ev & ~EM);
        live   = s.pend & en;
        clr    = (s.left == 0 && ack) ? s.irq : 4'h0;
        n.prev = ev;
        n.pend = (s.pend & ~clr) | hit;
        n.ovf  = (s.ovf & ~clr) | (hit & s.pend & ~clr);
        n.irq  = 4'h0;
        if (s.left < 0) begin
            if (live != 0) n.left = cc;
        end else if (s.left > 0) begin
            n.left = s.left - 1;
        end else if (ack || live == 0) begin
            n.left = -1;
        end else begin
            n.irq = live;
        end
        return n;
    endfunction

    always @(posedge clk)
        m <= step(m, rst, event_in, irq_enable, int'(coalesce_cycles), irq_reset);

    typedef struct {
        logic        r;
        logic [3:0]  ev, en;
        logic [15:0] cc;
        logic        ack;
        logic        ci;  logic [3:0] ei;
        logic        co;  logic [3:0] eo;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] ev, input logic [3:0] en,
                       input logic [15:0] cc, input logic ack, input logic ci,
                       input logic [3:0] ei, input logic co, input logic [3:0] eo, input int n);
        vec_t v;
        v = '{r: r, ev: ev, en: en, cc: cc, ack: ack, ci: ci, ei: ei, co: co, eo: eo};
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cmp("model_irq", irq, m.irq);
        cmp("model_overflow", overflow, m.ovf);
    endtask

    initial begin
        rst = 1'b1; event_in = '0; irq_enable = 4'hF; coalesce_cycles = '0; irq_reset = 1'b0;

        // reset with edge source held high, then rising-edge-on-release
        add(1, 4'b0010, 4'hF, 0, 0, 1, 4'b0000, 1, 4'b0000, 3);
        add(0, 4'b0010, 4'hF, 0, 0, 1, 4'b0000, 1, 4'b0000, 2);
        add(0, 4'b0010, 4'hF, 0, 0, 1, 4'b0010, 1, 4'b0000, 1);
        // acknowledge coinciding with a new edge on the same bit
        add(0, 4'b0000, 4'hF, 0, 0, 1, 4'b0010, 1, 4'b0000, 1);
        add(0, 4'b0010, 4'hF, 0, 1, 1, 4'b0000, 1, 4'b0000, 1);
        add(0, 4'b0000, 4'hF, 0, 0, 1, 4'b0000, 1, 4'b0000, 1);
        add(0, 4'b0000, 4'hF, 0, 0, 1, 4'b0010, 1, 4'b0000, 1);
        add(0, 4'b0000, 4'hF, 0, 1, 1, 4'b0000, 1, 4'b0000, 1);
        add(0, 4'b0000, 4'hF, 0, 0, 1, 4'b0000, 1, 4'b0000, 2);
        // coalescing 10 cycles: two sources merge into one assertion 13 cycles later
        add(0, 4'b0010, 4'hF, 10, 0, 1, 4'b0000, 1, 4'b0000, 1);
        add(0, 4'b0000, 4'hF, 10, 0, 1, 4'b0000, 1, 4'b0000, 4);
        add(0, 4'b1000, 4'hF, 10, 0, 1, 4'b0000, 1, 4'b0000, 1);
        add(0, 4'b0000, 4'hF, 10, 0, 1, 4'b0000, 1, 4'b0000, 6);
        add(0, 4'b0000, 4'hF, 10, 0, 1, 4'b1010, 1, 4'b0000, 1);
        add(0, 4'b0000, 4'hF, 0, 1, 1, 4'b0000, 1, 4'b0000, 1);
        add(0, 4'b0000, 4'hF, 0, 0, 1, 4'b0000, 1, 4'b0000, 1);
        // double event before acknowledge sets overflow
        add(0, 4'b0100, 4'hF, 0, 0, 1, 4'b0000, 1, 4'b0000, 1);
        add(0, 4'b0000, 4'hF, 0, 0, 1, 4'b0000, 1, 4'b0000, 1);
        add(0, 4'b0100, 4'hF, 0, 0, 1, 4'b0100, 1, 4'b0100, 1);
        add(0, 4'b0000, 4'hF, 0, 0, 1, 4'b0100, 1, 4'b0100, 1);
        add(0, 4'b0000, 4'hF, 0, 1, 1, 4'b0000, 1, 4'b0000, 1);
        add(0, 4'b0000, 4'hF, 0, 0, 1, 4'b0000, 1, 4'b0000, 1);
        // disabled source latches, fires two cycles after enabling
        add(0, 4'b0001, 4'hE, 0, 0, 1, 4'b0000, 1, 4'b0000, 1);
        add(0, 4'b0000, 4'hE, 0, 0, 1, 4'b0000, 1, 4'b0000, 100);
        add(0, 4'b0000, 4'hF, 0, 0, 1, 4'b0000, 1, 4'b0000, 1);
        add(0, 4'b0000, 4'hF, 0, 0, 1, 4'b0001, 1, 4'b0000, 1);
        add(0, 4'b0000, 4'hF, 0, 1, 1, 4'b0000, 1, 4'b0000, 1);
        add(0, 4'b0000, 4'hF, 0, 0, 1, 4'b0000, 1, 4'b0000, 1);
        // level source held high reasserts 3 cycles after acknowledge
        add(0, 4'b0001, 4'hF, 0, 0, 1, 4'b0000, 1, 4'b0000, 1);
        add(0, 4'b0001, 4'hF, 0, 0, 1, 4'b0000, 0, 4'b0000, 1);
        add(0, 4'b0001, 4'hF, 0, 0, 1, 4'b0001, 1, 4'b0001, 1);
        add(0, 4'b0001, 4'hF, 0, 1, 1, 4'b0000, 1, 4'b0000, 1);
        add(0, 4'b0001, 4'hF, 0, 0, 1, 4'b0000, 1, 4'b0001, 1);
        add(0, 4'b0001, 4'hF, 0, 0, 1, 4'b0001, 1, 4'b0001, 1);
        add(0, 4'b0000, 4'hF, 0, 1, 1, 4'b0000, 0, 4'b0000, 1);
        add(0, 4'b0000, 4'hF, 0, 0, 1, 4'b0000, 1, 4'b0000, 1);

        foreach (tbl[i]) begin
            rst = tbl[i].r; event_in = tbl[i].ev; irq_enable = tbl[i].en;
            coalesce_cycles = tbl[i].cc; irq_reset = tbl[i].ack;
            tick();
            if (tbl[i].ci) cmp($sformatf("vec%0d_irq", i), irq, tbl[i].ei);
            if (tbl[i].co) cmp($sformatf("vec%0d_overflow", i), overflow, tbl[i].eo);
        end

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 299) == 0);
            event_in  = 4'($urandom & $urandom & $urandom);
            irq_reset = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 49) == 0) irq_enable = 4'($urandom);
            if ($urandom_range(0, 39) == 0) coalesce_cycles = 16'($urandom_range(0, 6));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
